// File: rtl/key_event_encoder_if.sv
// Key event bus: debounced key levels in, buffered key-code events out over valid/ready.
// Latency: none (signal bundle only).
// Backpressure: key_ready from the consumer stalls the event FIFO inside the encoder.
interface key_event_encoder_if #(
    parameter int CODE_W = 4
) ();
    localparam int NKEYS = 2 ** CODE_W;

    logic [NKEYS-1:0]  pressed;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_ready;
    logic              overflow;
    logic              any_pressed;

    // Encoder side.
    modport master (
        input  pressed,
        input  key_ready,
        output key_code,
        output key_valid,
        output overflow,
        output any_pressed
    );

    // Key matrix / consumer side.
    modport slave (
        output pressed,
        output key_ready,
        input  key_code,
        input  key_valid,
        input  overflow,
        input  any_pressed
    );
endinterface

// File: rtl/key_event_encoder.sv
// Turns debounced per-key levels into one key-code event per press, queued in a small FIFO.
// Latency: press sampled at posedge k -> pending at k -> pushed at k+1 -> key_valid after k+1.
// Backpressure: key_ready low holds events in the FIFO, then in the pending mask; a re-press of a still-pending key is lost and pulses overflow.
// Optional auto-repeat of a single held key is enabled by defining KEY_AUTOREPEAT_EN.
module key_event_encoder #(
    parameter int CODE_W       = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic                clk_1000hz,
    input  logic                rst_n,
    key_event_encoder_if.master bus
);
    localparam int NKEYS = 2 ** CODE_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [NKEYS-1:0]  prev;
    logic [NKEYS-1:0]  pending;
    logic [NKEYS-1:0]  key_edge;
    logic [NKEYS-1:0]  served;
    logic [NKEYS-1:0]  rep_set;
    logic              overflow_q;
    logic              lost;

    logic [CODE_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;

    logic              svc_any;
    logic [CODE_W-1:0] svc_idx;

    // A key whose level is high now but was low at the previous tick has just been pressed.
    assign key_edge = bus.pressed & ~prev;

    // Pop uses only registered state plus key_ready; the outputs themselves never depend on key_ready.
    assign pop  = (count != '0) && bus.key_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push = svc_any && ((count != CNT_W'(FIFO_DEPTH)) || pop);

    assign served = push ? (NKEYS'(1) << svc_idx) : '0;

    // A fresh press on a key that is still waiting (and not leaving this cycle) cannot be represented.
    assign lost = |(key_edge & pending & ~served);

    // Pick the lowest-index pending key so simultaneous presses come out in ascending order.
    always_comb begin
        svc_any = 1'b0;
        svc_idx = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                svc_any = 1'b1;
                svc_idx = CODE_W'(i);
            end
        end
    end

    // Edge history, pending mask and the overflow pulse.
    always_ff @(posedge clk_1000hz or negedge rst_n) begin
        if (!rst_n) begin
            prev       <= '0;
            pending    <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev       <= bus.pressed;
            pending    <= (pending & ~served) | key_edge | rep_set;
            overflow_q <= lost;
        end
    end

    // Event FIFO storage and pointers; power-of-2 depth lets the pointers wrap naturally.
    always_ff @(posedge clk_1000hz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= svc_idx;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign bus.key_code    = fifo_mem[rd_ptr];
    assign bus.key_valid   = (count != '0);
    assign bus.overflow    = overflow_q;
    assign bus.any_pressed = |prev;

`ifdef KEY_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    typedef enum logic [1:0] {
        REP_OFF,
        REP_DELAY,
        REP_RATE
    } rep_state_t;

    rep_state_t       rep_state;
    rep_state_t       rep_state_nxt;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_cnt_nxt;
    logic             rep_fire;

    // Repeat state and cycle counter.
    always_ff @(posedge clk_1000hz or negedge rst_n) begin
        if (!rst_n) begin
            rep_state <= REP_OFF;
            rep_cnt   <= '0;
        end else begin
            rep_state <= rep_state_nxt;
            rep_cnt   <= rep_cnt_nxt;
        end
    end

    // Arm only on a lone fresh press; any later change of the held set disarms until the next lone press.
    always_comb begin
        rep_state_nxt = rep_state;
        rep_cnt_nxt   = rep_cnt;
        rep_fire      = 1'b0;
        if (bus.pressed != prev) begin
            rep_cnt_nxt = '0;
            if ($onehot(bus.pressed) && (|key_edge)) begin
                rep_state_nxt = REP_DELAY;
            end else begin
                rep_state_nxt = REP_OFF;
            end
        end else begin
            case (rep_state)
                REP_DELAY: begin
                    if (rep_cnt == REP_W'(REPEAT_DELAY - 1)) begin
                        rep_fire      = 1'b1;
                        rep_state_nxt = REP_RATE;
                        rep_cnt_nxt   = '0;
                    end else begin
                        rep_cnt_nxt = rep_cnt + 1'b1;
                    end
                end
                REP_RATE: begin
                    if (rep_cnt == REP_W'(REPEAT_RATE - 1)) begin
                        rep_fire    = 1'b1;
                        rep_cnt_nxt = '0;
                    end else begin
                        rep_cnt_nxt = rep_cnt + 1'b1;
                    end
                end
                default: begin
                    rep_cnt_nxt = '0;
                end
            endcase
        end
    end

    // A repeat re-marks the single held key; merging into an already-pending bit is silent.
    assign rep_set = rep_fire ? prev : '0;
`else
    logic unused_repeat_cfg;

    assign rep_set           = '0;
    assign unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
`endif

endmodule
